fir_mac_driver: RTL and testbench

- Sequencer that feeds the FIR MAC datapath. Per input sample it:
  - shifts the sample into a 10-tap, 3-bit delay chain;
  - reads the 10 coefficients from the coefficient SpSram;
  - issues exactly 10 aligned multiply/accumulate strobes with matching coefficients;
  - captures the MAC result as the filter output.
- Sits between the sample source, the coefficient SpSram read port and the MAC block.

---
 rtl/fir_mac_driver_if.sv | 33 +++
 rtl/fir_mac_driver.sv | 147 ++++++++++++++
 tb/tb_fir_mac_driver.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_mac_driver_if.sv
// Handshake/bus bundle for fir_mac_driver: sample source, coefficient SpSram read port and MAC.
// slave = the sequencer; master = the surrounding environment.
interface fir_mac_driver_if #(
  parameter int TAPS    = 10,
  parameter int DATA_W  = 3,
  parameter int COEFF_W = 16,
  parameter int ADDR_W  = 4
);
  logic                     iEnSample;
  logic [DATA_W-1:0]        iFirIn;
  logic                     oCs;
  logic [ADDR_W-1:0]        oAddr;
  logic [COEFF_W-1:0]       iRdData;
  logic [TAPS*DATA_W-1:0]   oDelay;
  logic [COEFF_W-1:0]       oCoeff;
  logic                     oEnMul;
  logic                     oEnAddAcc;
  logic [COEFF_W-1:0]       iMac;
  logic [COEFF_W-1:0]       oFirOut;
  logic                     oFirValid;
  logic                     oBusy;
  logic                     oDrop;

  modport slave (
    input  iEnSample, iFirIn, iRdData, iMac,
    output oCs, oAddr, oDelay, oCoeff, oEnMul, oEnAddAcc, oFirOut, oFirValid, oBusy, oDrop
  );

  modport master (
    output iEnSample, iFirIn, iRdData, iMac,
    input  oCs, oAddr, oDelay, oCoeff, oEnMul, oEnAddAcc, oFirOut, oFirValid, oBusy, oDrop
  );
endinterface

// File: rtl/fir_mac_driver.sv
// FIR MAC sequencer: delay chain, coefficient fetch, 10 aligned MAC strobes, result capture.
// Optional one-entry pending-sample buffer when FIR_SAMPLE_QUEUE_EN is defined.
//
//   state   | meaning
//   IDLE    | waiting for a sample strobe
//   READ    | cycles 1-10: oCs high, addresses 0..TAPS-1
//   MAC     | cycles 11-12: last strobes drain from the read pipeline
//   CAPTURE | cycle 13: iMac sampled into oFirOut
//   OUT     | cycle 14: oFirValid pulse; a new sample may be accepted
module fir_mac_driver #(
  parameter int TAPS    = 10,
  parameter int DATA_W  = 3,
  parameter int COEFF_W = 16,
  parameter int ADDR_W  = 4
) (
  input  logic              iClk12M,
  input  logic              iRst,
  fir_mac_driver_if.slave   bus
);
  typedef enum logic [2:0] {S_IDLE, S_READ, S_MAC, S_CAPTURE, S_OUT} state_t;

  localparam int CHAIN_W = TAPS * DATA_W;

  state_t               state_q;
  logic [ADDR_W-1:0]    addr_q;
  logic                 tmr_q;
  logic                 cs_q;
  logic                 rd_vld_q;
  logic                 en_mul_q;
  logic [COEFF_W-1:0]   coeff_q;
  logic [CHAIN_W-1:0]   chain_q;
  logic [CHAIN_W-1:0]   chain_d;
  logic [COEFF_W-1:0]   fir_out_q;
  logic                 valid_q;
  logic                 busy_q;
  logic                 drop_q;
  logic                 accept;
  logic [DATA_W-1:0]    accept_smp;

`ifdef FIR_SAMPLE_QUEUE_EN
  logic                 pend_vld_q;
  logic [DATA_W-1:0]    pend_q;

  // A buffered sample takes priority over a fresh strobe arriving in OUT.
  assign accept     = (state_q == S_IDLE && bus.iEnSample) ||
                      (state_q == S_OUT && (bus.iEnSample || pend_vld_q));
  assign accept_smp = (state_q == S_OUT && pend_vld_q) ? pend_q : bus.iFirIn;
`else
  assign accept     = (state_q == S_IDLE || state_q == S_OUT) && bus.iEnSample;
  assign accept_smp = bus.iFirIn;
`endif

  assign chain_d = {chain_q[CHAIN_W-DATA_W-1:0], accept_smp};

  always_ff @(posedge iClk12M) begin
    if (iRst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      tmr_q     <= 1'b0;
      cs_q      <= 1'b0;
      rd_vld_q  <= 1'b0;
      en_mul_q  <= 1'b0;
      coeff_q   <= '0;
      chain_q   <= '0;
      fir_out_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      drop_q    <= 1'b0;
`ifdef FIR_SAMPLE_QUEUE_EN
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
`endif
    end else begin
      valid_q  <= 1'b0;
      drop_q   <= 1'b0;
      // SpSram data lags oCs by one cycle; strobe follows the data register.
      rd_vld_q <= cs_q;
      en_mul_q <= rd_vld_q;
      if (rd_vld_q) coeff_q <= bus.iRdData;

      case (state_q)
        S_IDLE, S_OUT: begin
          if (accept) begin
            chain_q <= chain_d;
            state_q <= S_READ;
            cs_q    <= 1'b1;
            addr_q  <= '0;
            busy_q  <= 1'b1;
`ifdef FIR_SAMPLE_QUEUE_EN
            if (state_q == S_OUT && pend_vld_q) begin
              pend_vld_q <= bus.iEnSample;
              if (bus.iEnSample) pend_q <= bus.iFirIn;
            end
`endif
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_READ: begin
          if (addr_q == ADDR_W'(TAPS - 1)) begin
            cs_q    <= 1'b0;
            addr_q  <= '0;
            tmr_q   <= 1'b1;
            state_q <= S_MAC;
          end else begin
            addr_q <= addr_q + 1'b1;
          end
        end
        S_MAC: begin
          if (tmr_q == 1'b0) state_q <= S_CAPTURE;
          else               tmr_q   <= tmr_q - 1'b1;
        end
        S_CAPTURE: begin
          fir_out_q <= bus.iMac;
          valid_q   <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= S_OUT;
        end
        default: state_q <= S_IDLE;
      endcase

      if (busy_q && bus.iEnSample) begin
`ifdef FIR_SAMPLE_QUEUE_EN
        if (!pend_vld_q) begin
          pend_vld_q <= 1'b1;
          pend_q     <= bus.iFirIn;
        end else begin
          drop_q <= 1'b1;
        end
`else
        drop_q <= 1'b1;
`endif
      end
    end
  end

  assign bus.oCs       = cs_q;
  assign bus.oAddr     = addr_q;
  assign bus.oDelay    = chain_q;
  assign bus.oCoeff    = coeff_q;
  assign bus.oEnMul    = en_mul_q;
  assign bus.oEnAddAcc = en_mul_q;
  assign bus.oFirOut   = fir_out_q;
  assign bus.oFirValid = valid_q;
  assign bus.oBusy     = busy_q;
  assign bus.oDrop     = drop_q;
endmodule

// File: tb/tb_fir_mac_driver.sv
// Testbench for fir_mac_driver: SpSram and MAC models, sample-history reference model.
module tb_fir_mac_driver;
  logic clk = 1'b0;
  logic rst;
  always #41 clk = ~clk;

  fir_mac_driver_if bus ();

  fir_mac_driver dut (
    .iClk12M (clk),
    .iRst    (rst),
    .bus     (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] sram [10];
  int          taps [10];
  logic [2:0]  pend   = 3'd0;
  bit          pend_v = 1'b0;

  // Coefficient memory: one-cycle read latency, junk when not selected.
  always @(posedge clk) begin
    if (bus.oCs) bus.iRdData <= (bus.oAddr < 4'd10) ? sram[bus.oAddr] : 16'hDEAD;
    else         bus.iRdData <= 16'($urandom);
  end

  function automatic logic [15:0] mac_term(input int idx, input logic [29:0] d, input logic [15:0] c);
    logic signed [2:0] t;
    int p;
    t = d[3*idx +: 3];
    p = int'(c) * int'(t);
    return p[15:0];
  endfunction

  // MAC block: internal tap index wraps every 10 strobes, restarting the sum.
  int          mac_idx = 0;
  logic [15:0] mac_acc = 16'd0;
  logic [15:0] mac_nxt;
  always @(posedge clk) begin
    if (rst) begin
      mac_idx  <= 0;
      mac_acc  <= 16'd0;
      bus.iMac <= 16'd0;
    end else if (bus.oEnMul) begin
      mac_nxt   = mac_term(mac_idx, bus.oDelay, bus.oCoeff) + ((mac_idx == 0) ? 16'd0 : mac_acc);
      mac_acc  <= mac_nxt;
      bus.iMac <= mac_nxt;
      mac_idx  <= (mac_idx == 9) ? 0 : mac_idx + 1;
    end
  end

  bit mon_clr = 1'b0;
  int en_cnt = 0, val_cnt = 0, gap_bad = 0, cyc = 0, last_val = -1;
  always @(negedge clk) begin
    if (mon_clr) begin
      en_cnt = 0; val_cnt = 0; gap_bad = 0; cyc = 0; last_val = -1;
    end else begin
      cyc++;
      if (bus.oEnMul) en_cnt++;
      if (bus.oFirValid) begin
        val_cnt++;
        if (last_val >= 0 && cyc - last_val != 14) gap_bad++;
        last_val = cyc;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic void model_shift(input logic [2:0] s);
    for (int k = 9; k > 0; k--) taps[k] = taps[k-1];
    taps[0] = int'($signed(s));
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < 10; k++) taps[k] = 0;
    pend_v = 1'b0;
  endfunction

  function automatic logic [29:0] exp_delay();
    logic [29:0] d;
    for (int k = 0; k < 10; k++) d[3*k +: 3] = 3'(taps[k]);
    return d;
  endfunction

  function automatic logic [15:0] exp_out();
    int sum = 0;
    for (int k = 0; k < 10; k++) sum += int'(sram[k]) * taps[k];
    return sum[15:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One sample sequence. drive=0 relies on the pending buffer to start it.
  // inj>0 raises iEnSample during that cycle; last_n stops checking early.
  task automatic run_seq(input bit drive, input logic [2:0] smp, input int inj,
                         input logic [2:0] inj_smp, input int last_n);
    bit ecs, een, edrop;
    if (drive) begin
      bus.iEnSample = 1'b1;
      bus.iFirIn    = smp;
      model_shift(smp);
    end else begin
      model_shift(pend);
      pend_v = 1'b0;
    end
    step();
    bus.iEnSample = 1'b0;
    for (int n = 1; n <= last_n; n++) begin
      ecs = (n <= 10);
      een = (n >= 3 && n <= 12);
`ifdef FIR_SAMPLE_QUEUE_EN
      edrop = 1'b0;
`else
      edrop = (inj > 0 && n == inj + 1);
`endif
      chk("cs",     32'(bus.oCs),       32'(ecs));
      chk("addr",   32'(bus.oAddr),     ecs ? 32'(n - 1) : 32'd0);
      chk("enmul",  32'(bus.oEnMul),    32'(een));
      chk("enacc",  32'(bus.oEnAddAcc), 32'(een));
      if (een) chk("coeff", 32'(bus.oCoeff), 32'(sram[n-3]));
      chk("busy",   32'(bus.oBusy),     32'(n <= 13));
      chk("valid",  32'(bus.oFirValid), 32'(n == 14));
      chk("delay",  32'(bus.oDelay),    32'(exp_delay()));
      chk("drop",   32'(bus.oDrop),     32'(edrop));
      if (n == 14) chk("firout", 32'(bus.oFirOut), 32'(exp_out()));
      if (n == inj) begin
        bus.iEnSample = 1'b1;
        bus.iFirIn    = inj_smp;
`ifdef FIR_SAMPLE_QUEUE_EN
        pend   = inj_smp;
        pend_v = 1'b1;
`endif
      end
      if (n < last_n) begin
        step();
        bus.iEnSample = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.iEnSample = 1'b0;
    bus.iFirIn    = 3'd0;
    step();
    step();
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    int gap, inj;
    logic [2:0] s;
    model_clear();
    for (int k = 0; k < 10; k++) sram[k] = 16'(k + 1);
    do_reset();

    chk("rst_cs",    32'(bus.oCs),       32'd0);
    chk("rst_addr",  32'(bus.oAddr),     32'd0);
    chk("rst_delay", 32'(bus.oDelay),    32'd0);
    chk("rst_enmul", 32'(bus.oEnMul),    32'd0);
    chk("rst_out",   32'(bus.oFirOut),   32'd0);
    chk("rst_valid", 32'(bus.oFirValid), 32'd0);
    chk("rst_busy",  32'(bus.oBusy),     32'd0);
    chk("rst_drop",  32'(bus.oDrop),     32'd0);
    step();

    // Ramp coefficients: +1 then +2 back-to-back.
    run_seq(1'b1, 3'd1, 0, 3'd0, 14);
    chk("ramp1_delay", 32'(bus.oDelay), 32'h1);
    chk("ramp1_out",   32'(bus.oFirOut), 32'd1);
    run_seq(1'b1, 3'd2, 0, 3'd0, 14);
    chk("ramp2_delay", 32'(bus.oDelay), 32'h0A);
    chk("ramp2_out",   32'(bus.oFirOut), 32'd4);

    // Ten samples of -4 with unit coefficients.
    do_reset();
    for (int k = 0; k < 10; k++) sram[k] = 16'd1;
    for (int i = 0; i < 10; i++) run_seq(1'b1, 3'b100, 0, 3'd0, 14);
    chk("neg_out",   32'(bus.oFirOut), 32'h0000FFD8);
    chk("neg_delay", 32'(bus.oDelay),  32'h24924924);
    step();

    // Busy-time strobe at cycle 5.
    for (int k = 0; k < 10; k++) sram[k] = 16'($urandom);
    mon_clr = 1'b1; step(); mon_clr = 1'b0;
    run_seq(1'b1, 3'd3, 5, 3'd6, 14);
`ifdef FIR_SAMPLE_QUEUE_EN
    run_seq(1'b0, 3'd0, 0, 3'd0, 14);
    step(); step();
    chk("inj_strobes", 32'(en_cnt), 32'd20);
`else
    step(); step();
    chk("inj_strobes", 32'(en_cnt), 32'd10);
`endif

    // Reset in cycle 6 aborts the sequence.
    run_seq(1'b1, 3'($urandom_range(0, 7)), 0, 3'd0, 6);
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_clear();
    chk("abort_enmul", 32'(bus.oEnMul), 32'd0);
    chk("abort_cs",    32'(bus.oCs),    32'd0);
    chk("abort_busy",  32'(bus.oBusy),  32'd0);
    chk("abort_delay", 32'(bus.oDelay), 32'd0);
    step(); step();
    run_seq(1'b1, 3'd5, 0, 3'd0, 14);
    step();

    // Five back-to-back samples.
    mon_clr = 1'b1; step(); mon_clr = 1'b0;
    for (int i = 0; i < 5; i++) run_seq(1'b1, 3'($urandom_range(0, 7)), 0, 3'd0, 14);
    step(); step();
    chk("b2b_strobes", 32'(en_cnt),  32'd50);
    chk("b2b_valids",  32'(val_cnt), 32'd5);
    chk("b2b_spacing", 32'(gap_bad), 32'd0);

    // Randomized sequences with gaps and busy-time strobes.
    for (int i = 0; i < 24; i++) begin
      if (!pend_v) begin
        if ($urandom_range(0, 3) == 0)
          for (int k = 0; k < 10; k++) sram[k] = 16'($urandom);
        gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) step();
      end
      s   = 3'($urandom_range(0, 7));
      inj = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 13) : 0;
      run_seq(!pend_v, s, inj, 3'($urandom_range(0, 7)), 14);
    end
    if (pend_v) run_seq(1'b0, 3'd0, 0, 3'd0, 14);
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
